// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// uart_rx_byte : 8N1 UART receiver producing a held 8-bit command word
// Rev 1.0
// ============================================================================
module uart_rx_byte #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx_byte: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Synchronizer resets high so a reset never fabricates a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      out       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CPB_M1) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CPB_M1) begin
            cnt <= '0;
            if (rxs) begin
              out   <= shreg;
              valid <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line must not decode as a stream of 0x00 frames.
          cnt <= '0;
          if (rxs) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_byte : scoreboard bench for uart_rx_byte (CPB=16, HALF=8)
// Rev 1.0
// ============================================================================
module tb_uart_rx_byte;

  localparam int CLK_HZ = 160;
  localparam int BAUD   = 10;
  localparam int CPB    = 16;
  localparam int HALF   = 8;
  // Drive negedge -> t0 is 3 posedges later; pulse seen at stop-sample edge.
  localparam int LAT    = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .out       (out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid || frame_err) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", 32'({valid, frame_err}), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("pulse_kind", 32'({valid, frame_err}), mon_e.err ? 32'd1 : 32'd2);
        check("out_at_pulse", 32'(out), 32'(mon_e.data));
        check("pulse_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  // Called at a negedge; drives one full 8N1 frame and books the expected pulse.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    e.err  = ~stop;
    if (stop) last_good = b;
    e.data = last_good;
    e.at   = cyc + LAT;
    sbq.push_back(e);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int         bc;
    logic [7:0] b77;

    // 1. Reset
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // 2. Good frame
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("a5_sb_empty", 32'(sbq.size()), 32'd0);
    check("a5_out", 32'(out), 32'hA5);
    check("a5_opa", 32'(out[7:4]), 32'hA);
    check("a5_op", 32'(out[3:2]), 32'd1);

    // 3. Glitch rejection
    bc = 0;
    uart_rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 3) uart_rx = 1'b1;
      if (busy) bc++;
    end
    check("glitch_busy_cycles", 32'(bc), 32'd8);
    check("glitch_out_hold", 32'(out), 32'hA5);

    // 4. Framing error then held-low break
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    check("break_out_hold", 32'(out), 32'hA5);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("break_busy_before_drop", 32'(busy), 32'd1);
    @(negedge clk);
    check("break_busy_drop", 32'(busy), 32'd0);
    check("fe_sb_empty", 32'(sbq.size()), 32'd0);

    // 5. Back-to-back frames
    repeat (20) @(negedge clk);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_sb_empty", 32'(sbq.size()), 32'd0);
    check("b2b_out", 32'(out), 32'h5A);

    // 6. Reset mid-frame (during data bit 3 of 0x77), held until line idle
    b77 = 8'h77;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = b77[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = b77[3];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    last_good = 8'h00;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 4; i < 8; i++) begin
      uart_rx = b77[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (CPB + 10) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_out", 32'(out), 32'h00);
    send_frame(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_12_out", 32'(out), 32'h12);
    check("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
